// File: rtl/hdr_red_merge.sv
// Merges the red-channel response values g(Z) of one pixel's exposures into a single log-radiance value.
// Latency: the last sample is accepted at edge T; m_valid rises after edge T+21 (T+1 for a zero-weight group). clk_en stalls add cycles one for one.
// Backpressure: s_ready is high only while accumulating; the result is held on m_valid until m_ready, and the next group is not accepted before then.
//
// Ports:
//   clk, rst_n (sync, active-low), clk_en (global stall)
//   s_valid/s_ready, s_pixel (Z), s_g (g(Z)), s_exp (exposure index), s_last : sample input
//   m_valid/m_ready, m_data (signed ln E), m_sat (zero total weight), m_ovf (too many samples) : result
module hdr_red_merge #(
    parameter int                 NUM_EXP = 3,
    parameter logic signed [11:0] LN_DT0  = 12'sd0,
    parameter logic signed [11:0] LN_DT1  = 12'sd256,
    parameter logic signed [11:0] LN_DT2  = 12'sd512
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_en,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [4:0]  s_pixel,
    input  logic [11:0] s_g,
    input  logic [1:0]  s_exp,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [13:0] m_data,
    output logic        m_sat,
    output logic        m_ovf
);

    typedef enum logic [1:0] {ACC, DIV, OUT} state_t;

    localparam int            CW      = $clog2(NUM_EXP + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(NUM_EXP);

    state_t state, state_nxt;

    // Accumulators for the group in progress
    logic signed [19:0] num;
    logic [5:0]         den;
    logic [CW-1:0]      cnt;
    logic               ovf;

    // Divider: dvd shifts the dividend out of its top while quotient bits enter at the bottom
    logic [19:0] dvd;
    logic [5:0]  rem;
    logic [4:0]  div_cnt;
    logic        neg;

    logic [3:0]         w;
    logic signed [11:0] ln_dt;
    logic signed [13:0] t;
    logic signed [17:0] p;
    logic               acc_fire, out_fire, take;
    logic signed [19:0] num_nxt;
    logic [5:0]         den_nxt;
    logic [CW-1:0]      cnt_nxt;
    logic               ovf_nxt;
    logic [19:0]        num_mag;
    logic [6:0]         shifted, diff;
    logic               q_bit;
    logic [5:0]         rem_nxt;
    logic [19:0]        quot;

    // Datapath for the incoming sample and one divider step
    always_comb begin
        // Hat weight: 31 - Z for Z >= 16 equals the inverted low nibble
        w = s_pixel[4] ? ~s_pixel[3:0] : s_pixel[3:0];
        case (s_exp)
            2'd0:    ln_dt = LN_DT0;
            2'd1:    ln_dt = LN_DT1;
            default: ln_dt = LN_DT2;
        endcase
        t = $signed({2'b00, s_g}) - $signed({{2{ln_dt[11]}}, ln_dt});
        p = $signed({14'd0, w}) * $signed({{4{t[13]}}, t});

        acc_fire = clk_en && s_valid && (state == ACC);
        out_fire = clk_en && m_valid && m_ready;
        // Samples beyond the accumulator capacity are consumed but ignored
        take     = (cnt < CNT_MAX);
        num_nxt  = take ? (num + $signed({{2{p[17]}}, p})) : num;
        den_nxt  = take ? (den + {2'b00, w}) : den;
        cnt_nxt  = take ? (cnt + CW'(1)) : cnt;
        ovf_nxt  = ovf | ~take;
        num_mag  = num_nxt[19] ? 20'(-num_nxt) : 20'(num_nxt);

        shifted  = {rem, dvd[19]};
        diff     = shifted - {1'b0, den};
        q_bit    = (shifted >= {1'b0, den});
        rem_nxt  = q_bit ? diff[5:0] : shifted[5:0];
        quot     = {dvd[18:0], q_bit};
    end

    // Next-state and input handshake
    always_comb begin
        state_nxt = state;
        s_ready   = clk_en && (state == ACC);
        case (state)
            ACC: if (acc_fire && s_last)
                     state_nxt = (den_nxt != 6'd0) ? DIV : OUT;
            DIV: if (clk_en && div_cnt == 5'd19)
                     state_nxt = OUT;
            OUT: if (out_fire)
                     state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ACC;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num     <= '0;
            den     <= '0;
            cnt     <= '0;
            ovf     <= 1'b0;
            dvd     <= '0;
            rem     <= '0;
            div_cnt <= '0;
            neg     <= 1'b0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sat   <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (clk_en) begin
            case (state)
                ACC: begin
                    if (acc_fire) begin
                        num <= num_nxt;
                        den <= den_nxt;
                        cnt <= cnt_nxt;
                        ovf <= ovf_nxt;
                        if (s_last) begin
                            m_ovf   <= ovf_nxt;
                            dvd     <= num_mag;
                            neg     <= num_nxt[19];
                            rem     <= '0;
                            div_cnt <= '0;
                            if (den_nxt == 6'd0) begin
                                m_data <= '0;
                                m_sat  <= 1'b1;
                            end else begin
                                m_sat  <= 1'b0;
                            end
                        end
                    end
                end
                DIV: begin
                    dvd     <= quot;
                    rem     <= rem_nxt;
                    div_cnt <= div_cnt + 5'd1;
                    // Magnitude never exceeds 6143, so the low 14 bits carry the full result
                    if (div_cnt == 5'd19)
                        m_data <= neg ? (14'd0 - quot[13:0]) : quot[13:0];
                end
                OUT: begin
                    // m_valid trails entry into OUT by one cycle
                    if (out_fire) begin
                        num     <= '0;
                        den     <= '0;
                        cnt     <= '0;
                        ovf     <= 1'b0;
                        m_valid <= 1'b0;
                    end else begin
                        m_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hdr_red_merge.sv
// Bench for hdr_red_merge: table of known groups, hand-written control sequences, random groups vs a reference model.
// Latency: checks result latency of 21 cycles (1 for zero-weight groups), stretched by stalls.
// Backpressure: exercises held results under m_ready low and random clk_en stalls.
module tb_hdr_red_merge;

    logic        clk = 1'b0;
    logic        rst_n, clk_en, s_valid, s_ready, s_last;
    logic        m_valid, m_ready, m_sat, m_ovf;
    logic [4:0]  s_pixel;
    logic [11:0] s_g;
    logic [1:0]  s_exp;
    logic [13:0] m_data;

    int checks   = 0;
    int failures = 0;
    bit rand_en  = 1'b0;

    typedef struct packed {
        logic [2:0]        n;
        logic [3:0][4:0]   z;
        logic [3:0][11:0]  g;
        logic [3:0][1:0]   e;
        int                exp_data;
        logic              exp_sat;
        logic              exp_ovf;
        int                exp_lat;
    } vec_t;

    vec_t tbl [7];

    hdr_red_merge dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
        .s_valid(s_valid), .s_ready(s_ready), .s_pixel(s_pixel), .s_g(s_g),
        .s_exp(s_exp), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sat(m_sat), .m_ovf(m_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    // One clock; inputs and optional random clk_en change mid-cycle, checks happen after that
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_en) clk_en = ($urandom_range(0, 3) != 0);
        #1;
    endtask

    task automatic send(input int z, input int g, input int e, input bit last);
        bit fire;
        int b = 0;
        s_valid = 1'b1;
        s_pixel = z[4:0];
        s_g     = g[11:0];
        s_exp   = e[1:0];
        s_last  = last;
        do begin
            fire = s_ready;
            step();
            b++;
        end while (!fire && b < 300);
        if (!fire) chk("send timeout", 0, 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!m_valid && lat < 300) begin
            step();
            lat++;
        end
    endtask

    task automatic take_output();
        bit fire;
        int b = 0;
        m_ready = 1'b1;
        do begin
            fire = m_valid && clk_en;
            step();
            b++;
        end while (!fire && b < 300);
        if (!fire) chk("accept timeout", 0, 1);
        m_ready = 1'b0;
    endtask

    task automatic run_group(input vec_t v, input bit strict, input string nm);
        int lat;
        for (int k = 0; k < int'(v.n); k++)
            send(int'(v.z[k]), int'(v.g[k]), int'(v.e[k]), k == int'(v.n) - 1);
        wait_valid(lat);
        if (strict) chk({nm, " latency"}, lat, v.exp_lat);
        else        chk({nm, " valid"}, int'(m_valid), 1);
        if (!strict) repeat ($urandom_range(0, 3)) step();
        chk({nm, " data"}, int'($signed(m_data)), v.exp_data);
        chk({nm, " sat"},  int'(m_sat), int'(v.exp_sat));
        chk({nm, " ovf"},  int'(m_ovf), int'(v.exp_ovf));
        take_output();
        chk({nm, " valid after accept"}, int'(m_valid), 0);
        if (strict) chk({nm, " s_ready after accept"}, int'(s_ready), 1);
    endtask

    function automatic void set_s(input int i, input int k, input int z, input int g, input int e);
        tbl[i].z[k] = z[4:0];
        tbl[i].g[k] = g[11:0];
        tbl[i].e[k] = e[1:0];
    endfunction

    function automatic void set_x(input int i, input int n, input int d, input bit sat,
                                  input bit ovf, input int lat);
        tbl[i].n        = n[2:0];
        tbl[i].exp_data = d;
        tbl[i].exp_sat  = sat;
        tbl[i].exp_ovf  = ovf;
        tbl[i].exp_lat  = lat;
    endfunction

    // Reference: weighted mean of (g - ln dt) over the first three samples, truncated toward zero
    function automatic vec_t model(input vec_t v);
        int num = 0;
        int den = 0;
        for (int k = 0; k < int'(v.n); k++) begin
            if (k < 3) begin
                int z  = int'(v.z[k]);
                int e  = int'(v.e[k]);
                int w  = (z <= 15) ? z : 31 - z;
                int ln = (e == 0) ? 0 : (e == 1) ? 256 : 512;
                num += w * (int'(v.g[k]) - ln);
                den += w;
            end
        end
        v.exp_ovf = (int'(v.n) > 3);
        if (den == 0) begin
            v.exp_data = 0;
            v.exp_sat  = 1'b1;
            v.exp_lat  = 1;
        end else begin
            v.exp_data = num / den;
            v.exp_sat  = 1'b0;
            v.exp_lat  = 21;
        end
        return v;
    endfunction

    initial begin
        int   lat;
        vec_t v;

        for (int i = 0; i < 7; i++) tbl[i] = '0;
        set_s(0, 0, 8, 716, 0);                                             set_x(0, 1, 716, 0, 0, 21);
        set_s(1, 0, 4, 483, 0); set_s(1, 1, 16, 976, 1); set_s(1, 2, 28, 1290, 2); set_x(1, 3, 684, 0, 0, 21);
        set_s(2, 0, 1, 117, 1); set_s(2, 1, 2, 246, 2);                     set_x(2, 2, -223, 0, 0, 21);
        set_s(3, 0, 0, 123, 0); set_s(3, 1, 31, 4000, 1);                   set_x(3, 2, 0, 1, 0, 1);
        for (int k = 0; k < 4; k++) set_s(4, k, 8, 716, 0);                 set_x(4, 4, 716, 0, 1, 21);
        for (int k = 0; k < 3; k++) set_s(5, k, 15, 4095, 0);               set_x(5, 3, 4095, 0, 0, 21);
        for (int k = 0; k < 3; k++) set_s(6, k, 16, 0, 3);                  set_x(6, 3, -512, 0, 0, 21);

        rst_n = 1'b0; clk_en = 1'b1; s_valid = 1'b0; s_last = 1'b0;
        s_pixel = '0; s_g = '0; s_exp = '0; m_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        chk("reset m_valid", int'(m_valid), 0);
        chk("reset m_data",  int'(m_data), 0);
        chk("reset m_sat",   int'(m_sat), 0);
        chk("reset m_ovf",   int'(m_ovf), 0);
        chk("reset s_ready", int'(s_ready), 1);

        for (int i = 0; i < 7; i++) run_group(tbl[i], 1'b1, $sformatf("vec%0d", i));

        // Result held while downstream is not ready
        send(8, 716, 0, 1'b1);
        wait_valid(lat);
        for (int c = 0; c < 5; c++) begin
            chk("hold data",    int'($signed(m_data)), 716);
            chk("hold s_ready", int'(s_ready), 0);
            chk("hold valid",   int'(m_valid), 1);
            step();
        end
        take_output();
        chk("hold valid after accept", int'(m_valid), 0);

        // Reset in the middle of a division
        send(8, 716, 0, 1'b1);
        repeat (9) step();
        rst_n = 1'b0;
        step();
        chk("mid-div reset m_valid", int'(m_valid), 0);
        chk("mid-div reset s_ready", int'(s_ready), 1);
        rst_n = 1'b1;
        run_group(tbl[0], 1'b1, "after reset");

        // Stalls: s_ready forced low, latency stretched by the stalled cycles
        clk_en = 1'b0;
        #1;
        chk("stall s_ready", int'(s_ready), 0);
        clk_en = 1'b1;
        #1;
        send(4, 483, 0, 1'b1);
        clk_en = 1'b0;
        repeat (3) step();
        chk("stall m_valid", int'(m_valid), 0);
        clk_en = 1'b1;
        wait_valid(lat);
        chk("stall latency", lat + 3, 24);
        chk("stall data", int'($signed(m_data)), 483);
        take_output();

        // Random groups with random stalls and downstream delay
        rand_en = 1'b1;
        for (int r = 0; r < 40; r++) begin
            bit zero_grp = ($urandom_range(0, 5) == 0);
            v   = '0;
            v.n = 3'($urandom_range(1, 4));
            for (int k = 0; k < 4; k++) begin
                if (zero_grp || $urandom_range(0, 4) == 0)
                    v.z[k] = ($urandom_range(0, 1) != 0) ? 5'd31 : 5'd0;
                else
                    v.z[k] = 5'($urandom_range(0, 31));
                v.g[k] = 12'($urandom_range(0, 4095));
                v.e[k] = 2'($urandom_range(0, 3));
            end
            v = model(v);
            run_group(v, 1'b0, $sformatf("rand%0d", r));
        end
        rand_en = 1'b0;
        clk_en  = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
